// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: runs one req/ack read to instruction memory per accepted
// fetch_start and holds the result for decode. Optional REQ timeout: FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        fetch_start,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } stateT;

  stateT state;
  stateT stateNxt;

  logic [XLEN-1:0] imemAddrNxt;
  logic            imemReqNxt;
  logic [XLEN-1:0] instrOutNxt;
  logic            instrValidNxt;
  logic [XLEN-1:0] pcPlus4Nxt;
  logic            fetchBusyNxt;
  logic            fetchErrNxt;

  logic pcAligned;
  logic timeoutHit;

  assign pcAligned = (pc_in[1:0] == 2'b00);

  // The limit must allow at least one REQ cycle; reject bad configurations at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] toCnt;

  // Abort fires on the edge that would make the count reach the limit, unless ack wins.
  assign timeoutHit = (state == REQ) && !imem_ack &&
                      (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toCnt <= '0;
    end else if (state == IDLE) begin
      toCnt <= '0;
    end else if (!imem_ack && !timeoutHit) begin
      toCnt <= toCnt + CNT_W'(1);
    end else begin
      toCnt <= '0;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      imem_addr   <= '0;
      imem_req    <= 1'b0;
      instr_out   <= RESET_INSTR;
      instr_valid <= 1'b0;
      pc_plus4    <= '0;
      fetch_busy  <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= stateNxt;
      imem_addr   <= imemAddrNxt;
      imem_req    <= imemReqNxt;
      instr_out   <= instrOutNxt;
      instr_valid <= instrValidNxt;
      pc_plus4    <= pcPlus4Nxt;
      fetch_busy  <= fetchBusyNxt;
      fetch_err   <= fetchErrNxt;
    end
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (fetch_start && pcAligned) begin
          stateNxt = REQ;
        end
      end
      REQ: begin
        if (imem_ack || timeoutHit) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Output next values; fetch_start during REQ (including the ack cycle) is dropped.
  always_comb begin
    imemAddrNxt   = imem_addr;
    imemReqNxt    = imem_req;
    instrOutNxt   = instr_out;
    instrValidNxt = instr_valid;
    pcPlus4Nxt    = pc_plus4;
    fetchBusyNxt  = fetch_busy;
    fetchErrNxt   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_start) begin
          instrValidNxt = 1'b0;
          if (pcAligned) begin
            imemAddrNxt  = pc_in;
            imemReqNxt   = 1'b1;
            fetchBusyNxt = 1'b1;
          end else begin
            fetchErrNxt = 1'b1;
          end
        end
      end
      REQ: begin
        if (imem_ack) begin
          instrOutNxt   = imem_rdata;
          instrValidNxt = 1'b1;
          pcPlus4Nxt    = imem_addr + XLEN'(4);
          imemReqNxt    = 1'b0;
          fetchBusyNxt  = 1'b0;
        end else if (timeoutHit) begin
          imemReqNxt   = 1'b0;
          fetchBusyNxt = 1'b0;
          fetchErrNxt  = 1'b1;
        end
      end
      default: begin
        imemReqNxt   = 1'b0;
        fetchBusyNxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; timeout checks follow FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcIn;
  logic        fetchStart;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instrOut;
  logic        instrValid;
  logic [31:0] pcPlus4;
  logic        fetchBusy;
  logic        fetchErr;

  int nChecks = 0;
  int nFails  = 0;

  instr_fetch_unit #(
    .RESET_INSTR   (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pcIn),
    .fetch_start(fetchStart),
    .imem_addr  (imemAddr),
    .imem_req   (imemReq),
    .imem_ack   (imemAck),
    .imem_rdata (imemRdata),
    .instr_out  (instrOut),
    .instr_valid(instrValid),
    .pc_plus4   (pcPlus4),
    .fetch_busy (fetchBusy),
    .fetch_err  (fetchErr)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pcIn = '0; fetchStart = 1'b0; imemAck = 1'b0; imemRdata = '0;
    #3;
    checkEq("rst_req_async", 32'(imemReq), 32'd0);
    ticks(2);
    reset = 1'b0;
    ticks(5);
    checkEq("idle_instr", instrOut, 32'h0);
    checkEq("idle_valid", 32'(instrValid), 32'd0);
    checkEq("idle_req", 32'(imemReq), 32'd0);
    checkEq("idle_busy", 32'(fetchBusy), 32'd0);
    checkEq("idle_err", 32'(fetchErr), 32'd0);
    checkEq("idle_pc4", pcPlus4, 32'h0);
    checkEq("idle_addr", imemAddr, 32'h0);

    // Normal fetch, ack in third REQ cycle
    pcIn = 32'h0000_0040; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    checkEq("f1_req", 32'(imemReq), 32'd1);
    checkEq("f1_addr", imemAddr, 32'h0000_0040);
    checkEq("f1_busy", 32'(fetchBusy), 32'd1);
    checkEq("f1_valid0", 32'(instrValid), 32'd0);
    ticks(2);
    checkEq("f1_req_hold", 32'(imemReq), 32'd1);
    imemAck = 1'b1; imemRdata = 32'h2008_0005;
    tick();
    imemAck = 1'b0;
    checkEq("f1_instr", instrOut, 32'h2008_0005);
    checkEq("f1_valid", 32'(instrValid), 32'd1);
    checkEq("f1_pc4", pcPlus4, 32'h0000_0044);
    checkEq("f1_req_done", 32'(imemReq), 32'd0);
    checkEq("f1_busy_done", 32'(fetchBusy), 32'd0);

    // Misaligned PC
    pcIn = 32'h0000_0042; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    checkEq("mis_err", 32'(fetchErr), 32'd1);
    checkEq("mis_req", 32'(imemReq), 32'd0);
    checkEq("mis_valid", 32'(instrValid), 32'd0);
    checkEq("mis_instr", instrOut, 32'h2008_0005);
    checkEq("mis_pc4", pcPlus4, 32'h0000_0044);
    tick();
    checkEq("mis_err_pulse", 32'(fetchErr), 32'd0);
    checkEq("mis_req_stay", 32'(imemReq), 32'd0);

    // Wraparound PC with immediate ack
    pcIn = 32'hFFFF_FFFC; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    checkEq("wrap_valid0", 32'(instrValid), 32'd0);
    imemAck = 1'b1; imemRdata = 32'h8C09_0000;
    tick();
    imemAck = 1'b0;
    checkEq("wrap_valid", 32'(instrValid), 32'd1);
    checkEq("wrap_pc4", pcPlus4, 32'h0000_0000);
    checkEq("wrap_instr", instrOut, 32'h8C09_0000);

    // Stray ack with req low
    imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF;
    tick();
    imemAck = 1'b0;
    checkEq("stray_instr", instrOut, 32'h8C09_0000);
    checkEq("stray_valid", 32'(instrValid), 32'd1);
    checkEq("stray_req", 32'(imemReq), 32'd0);

    // Start during REQ ignored; start with completing ack ignored
    pcIn = 32'h0000_0200; fetchStart = 1'b1;
    tick();
    pcIn = 32'h0000_0100;
    tick();
    fetchStart = 1'b0;
    checkEq("busy_start_addr", imemAddr, 32'h0000_0200);
    checkEq("busy_start_req", 32'(imemReq), 32'd1);
    pcIn = 32'h0000_0300; fetchStart = 1'b1; imemAck = 1'b1; imemRdata = 32'h0000_0020;
    tick();
    fetchStart = 1'b0; imemAck = 1'b0;
    checkEq("ackstart_req", 32'(imemReq), 32'd0);
    checkEq("ackstart_valid", 32'(instrValid), 32'd1);
    checkEq("ackstart_pc4", pcPlus4, 32'h0000_0204);
    checkEq("ackstart_instr", instrOut, 32'h0000_0020);

    // Reset mid-REQ drops req at once
    pcIn = 32'h0000_0400; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    checkEq("mrst_req_pre", 32'(imemReq), 32'd1);
    #2;
    reset = 1'b1; imemAck = 1'b1; imemRdata = 32'h1234_5678;
    #1;
    checkEq("mrst_req", 32'(imemReq), 32'd0);
    checkEq("mrst_busy", 32'(fetchBusy), 32'd0);
    checkEq("mrst_instr", instrOut, 32'h0);
    tick();
    imemAck = 1'b0;
    reset = 1'b0;
    tick();
    checkEq("mrst_valid", 32'(instrValid), 32'd0);
    checkEq("mrst_addr", imemAddr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Timeout after 4 REQ cycles
    pcIn = 32'h0000_0080; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    ticks(3);
    checkEq("to_req_hold", 32'(imemReq), 32'd1);
    checkEq("to_err_early", 32'(fetchErr), 32'd0);
    tick();
    checkEq("to_req", 32'(imemReq), 32'd0);
    checkEq("to_busy", 32'(fetchBusy), 32'd0);
    checkEq("to_err", 32'(fetchErr), 32'd1);
    checkEq("to_valid", 32'(instrValid), 32'd0);
    tick();
    checkEq("to_err_pulse", 32'(fetchErr), 32'd0);
    // Ack on the limit cycle wins
    fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    ticks(3);
    imemAck = 1'b1; imemRdata = 32'hABCD_0001;
    tick();
    imemAck = 1'b0;
    checkEq("tolim_valid", 32'(instrValid), 32'd1);
    checkEq("tolim_err", 32'(fetchErr), 32'd0);
    checkEq("tolim_instr", instrOut, 32'hABCD_0001);
`else
    // No timeout: req waits indefinitely
    pcIn = 32'h0000_0080; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    ticks(50);
    checkEq("nto_req", 32'(imemReq), 32'd1);
    checkEq("nto_err", 32'(fetchErr), 32'd0);
    imemAck = 1'b1; imemRdata = 32'hABCD_0001;
    tick();
    imemAck = 1'b0;
    checkEq("nto_valid", 32'(instrValid), 32'd1);
    checkEq("nto_pc4", pcPlus4, 32'h0000_0084);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
